branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the IF stage: a direct-mapped branch target buffer plus per-entry saturating direction counters. IF looks up `pc` every cycle and gets a predicted next fetch address. The ID branch generator reports each resolved control-transfer instruction back to this block. The block trains its tables from those reports and raises a registered redirect when the carried prediction was wrong.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: instruction address width.
- `INDEX_BITS`, 4: log2 of entry count (ENTRIES = 2^INDEX_BITS); legal range 1..10.
- `CTR_BITS`, 2: direction counter width; legal range 1..4.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lookup_pc`  in  ADDR_WIDTH  IF fetch address (word aligned).
- `pred_taken`  out  1  predicted taken.
- `pred_target`  out  ADDR_WIDTH  predicted next fetch address.
- `upd_valid`  in  1  ID resolved a control-transfer instruction this cycle.
- `upd_pc`  in  ADDR_WIDTH  address of the resolved instruction.
- `upd_taken`  in  1  actual outcome (branch_flag from ID).
- `upd_target`  in  ADDR_WIDTH  actual target (branch_addr from ID); meaningful only when taken.
- `upd_pred_taken`  in  1  prediction carried down the pipeline for this instruction.
- `upd_pred_target`  in  ADDR_WIDTH  predicted address carried down the pipeline for this instruction.
- `flush_all`  in  1  invalidate every entry.
- `redirect`  out  1  registered mispredict pulse.
- `redirect_addr`  out  ADDR_WIDTH  registered correct fetch address.
- `mispredict_cnt`  out  32  wrapping count of mispredicts.

## Operation
- Fields: index = pc[INDEX_BITS+1:2]; tag = pc[ADDR_WIDTH-1:INDEX_BITS+2]; pc[1:0] is ignored.
- Entry contents: valid, tag, target[ADDR_WIDTH-1:2] (low bits read back as 00), ctr[CTR_BITS-1:0].
- Lookup (combinational):
  - hit = valid && tag match.
  - pred_taken = hit && ctr MSB.
  - pred_target = pred_taken ? {target,2'b00} : lookup_pc+4, modulo 2^ADDR_WIDTH.
- Update when `upd_valid`:
  - hit, taken: ctr saturating increment; target <= upd_target.
  - hit, not taken: ctr saturating decrement; target unchanged.
  - miss, taken: allocate entry. valid=1, tag, target written, ctr = 2^(CTR_BITS-1) (weakly taken). Replaces any previous occupant.
  - miss, not taken: no table change.
- Mispredict condition: upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
- Correct address = upd_taken ? upd_target : upd_pc+4.
- `flush_all`: clears all valid bits; ctr and target are left unchanged. Has priority over a same-cycle table update. The mispredict/redirect path still evaluates in that cycle.
- `mispredict_cnt` increments once per mispredict and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - all valid = 0; ctr = 2^(CTR_BITS-1)-1 (weakly not taken); target = 0; tag = 0.
  - redirect = 0, redirect_addr = 0, mispredict_cnt = 0.
  - Reset asserted mid-operation discards any pending update.
- Lookup latency: 0 cycles, purely combinational from `lookup_pc` and table state.
- Table writes occur at the rising edge where `upd_valid` is sampled. Effect on lookups is visible from the next cycle.
- Same-cycle lookup and update of the same index: the lookup returns pre-update contents; there is no forwarding.
- `redirect`/`redirect_addr`:
  - registered; assert exactly one cycle after the mispredicting update; single-cycle pulse.
  - Back-to-back mispredicts give consecutive pulses with independent addresses.
  - `redirect_addr` holds its last value when `redirect` = 0.

## Structure
- Default parameter values and the counter init/threshold constants go in the shared defines header alongside `bus.v` (`bp.v`).
- One sub-module, `sat_counter`: parametrised by CTR_BITS; inputs inc/dec/load/load_val; saturates at 0 and 2^CTR_BITS-1.
- Tables are flat register arrays; no RAM macro, so reset and `flush_all` can clear them.

## Test plan
- Reset, then lookup 0x0040_0010 -> pred_taken=0, pred_target=0x0040_0014, redirect=0, mispredict_cnt=0.
- Update pc 0x0040_0010 taken to 0x0040_0100 with upd_pred_taken=0:
  - next cycle: redirect=1, redirect_addr=0x0040_0100, mispredict_cnt=1.
  - lookup of 0x0040_0010 -> pred_taken=1, pred_target=0x0040_0100.
- Aliasing: with INDEX_BITS=4, update 0x0040_0050 taken.
  - lookup 0x0040_0010 -> miss, pred_target=0x0040_0014.
  - 0x0040_0050 hits.
- Counter saturation: 3 taken then 2 not-taken updates on one pc -> ctr 2→3→3→2→1; final lookup predicts not taken.
- Same-cycle update and lookup on one index -> old prediction returned; new prediction appears the next cycle. With `flush_all` asserted the same cycle: no hit afterwards, but redirect still fires if the update mispredicts.
- Wrap: preload mispredict_cnt near 0xFFFFFFFF via repeated mispredicts (or force) -> next mispredict gives 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// branch_predictor_pkg : shared defaults, counter constants, update actions
// Revision: 1.0
// ============================================================================
package branch_predictor_pkg;

   localparam int c_DEF_ADDR_WIDTH = 32;
   localparam int c_DEF_INDEX_BITS = 4;
   localparam int c_DEF_CTR_BITS   = 2;

   typedef enum logic [1:0] {
      UPD_NONE  = 2'd0,
      UPD_INC   = 2'd1,
      UPD_DEC   = 2'd2,
      UPD_ALLOC = 2'd3
   } upd_action_e;

   // Weakly not taken: just below the taken threshold.
   function automatic int ctr_init_val(input int bits);
      return (1 << (bits - 1)) - 1;
   endfunction

   // Weakly taken: the taken threshold itself.
   function automatic int ctr_alloc_val(input int bits);
      return 1 << (bits - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// branch_predictor_if : IF lookup, ID resolve/update and redirect signals
// Revision: 1.0
// ============================================================================
interface branch_predictor_if
   import branch_predictor_pkg::*;
#(
   parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
);
   logic [ADDR_WIDTH-1:0] lookup_pc;
   logic                  pred_taken;
   logic [ADDR_WIDTH-1:0] pred_target;
   logic                  upd_valid;
   logic [ADDR_WIDTH-1:0] upd_pc;
   logic                  upd_taken;
   logic [ADDR_WIDTH-1:0] upd_target;
   logic                  upd_pred_taken;
   logic [ADDR_WIDTH-1:0] upd_pred_target;
   logic                  flush_all;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_addr;
   logic [31:0]           mispredict_cnt;

   modport master (
      output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target, flush_all,
      input  pred_taken, pred_target, redirect, redirect_addr, mispredict_cnt
   );

   modport slave (
      input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target, flush_all,
      output pred_taken, pred_target, redirect, redirect_addr, mispredict_cnt
   );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : up/down counter saturating at 0 and 2^CTR_BITS-1, with load
// Revision: 1.0
// ============================================================================
module sat_counter #(
   parameter int                  CTR_BITS  = 2,
   parameter logic [CTR_BITS-1:0] RESET_VAL = '0
) (
   input  wire logic                clk,
   input  wire logic                rst_n,
   input  wire logic                i_inc,
   input  wire logic                i_dec,
   input  wire logic                i_load,
   input  wire logic [CTR_BITS-1:0] i_load_val,
   output logic      [CTR_BITS-1:0] o_count
);
   localparam logic [CTR_BITS-1:0] c_MAX = '1;

   logic [CTR_BITS-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= RESET_VAL;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_inc && !i_dec) begin
         if (r_count != c_MAX) r_count <= r_count + 1'b1;
      end else if (i_dec && !i_inc) begin
         if (r_count != '0) r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// branch_predictor : direct-mapped BTB with per-entry direction counters
// Revision: 1.0
// ============================================================================
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
   parameter int INDEX_BITS = c_DEF_INDEX_BITS,
   parameter int CTR_BITS   = c_DEF_CTR_BITS
) (
   input wire logic          clk,
   input wire logic          rst_n,
   branch_predictor_if.slave bp
);
   localparam int c_ENTRIES = 1 << INDEX_BITS;
   localparam int c_TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;
   localparam int c_TGT_W   = ADDR_WIDTH - 2;
   localparam logic [CTR_BITS-1:0] c_CTR_INIT  = CTR_BITS'(ctr_init_val(CTR_BITS));
   localparam logic [CTR_BITS-1:0] c_CTR_ALLOC = CTR_BITS'(ctr_alloc_val(CTR_BITS));

   logic [c_ENTRIES-1:0] r_valid;
   logic [c_TAG_W-1:0]   r_tag    [c_ENTRIES];
   logic [c_TGT_W-1:0]   r_target [c_ENTRIES];
   logic [CTR_BITS-1:0]  w_ctr    [c_ENTRIES];

   logic [INDEX_BITS-1:0] w_lk_idx;
   logic [c_TAG_W-1:0]    w_lk_tag;
   logic                  w_lk_hit;
   logic [CTR_BITS-1:0]   w_lk_ctr;
   logic                  w_pred_taken;

   logic [INDEX_BITS-1:0] w_up_idx;
   logic [c_TAG_W-1:0]    w_up_tag;
   logic                  w_up_hit;
   upd_action_e           w_action;

   logic                  w_mispredict;
   logic [ADDR_WIDTH-1:0] w_correct_addr;

   logic                  r_redirect;
   logic [ADDR_WIDTH-1:0] r_redirect_addr;
   logic [31:0]           r_mispredict_cnt;

   assign w_lk_idx     = bp.lookup_pc[INDEX_BITS+1:2];
   assign w_lk_tag     = bp.lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
   assign w_lk_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
   assign w_lk_ctr     = w_ctr[w_lk_idx];
   assign w_pred_taken = w_lk_hit && w_lk_ctr[CTR_BITS-1];

   assign bp.pred_taken  = w_pred_taken;
   assign bp.pred_target = w_pred_taken ? {r_target[w_lk_idx], 2'b00}
                                        : bp.lookup_pc + ADDR_WIDTH'(4);

   assign w_up_idx = bp.upd_pc[INDEX_BITS+1:2];
   assign w_up_tag = bp.upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];
   assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

   // Flush suppresses training entirely; a not-taken miss leaves the table alone.
   always_comb begin
      w_action = UPD_NONE;
      if (bp.upd_valid && !bp.flush_all) begin
         if (w_up_hit)          w_action = bp.upd_taken ? UPD_INC : UPD_DEC;
         else if (bp.upd_taken) w_action = UPD_ALLOC;
      end
   end

   for (genvar gi = 0; gi < c_ENTRIES; gi++) begin : g_entry
      logic w_sel;
      assign w_sel = (w_up_idx == INDEX_BITS'(gi));

      sat_counter #(
         .CTR_BITS  (CTR_BITS),
         .RESET_VAL (c_CTR_INIT)
      ) u_ctr (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_inc      (w_sel && (w_action == UPD_INC)),
         .i_dec      (w_sel && (w_action == UPD_DEC)),
         .i_load     (w_sel && (w_action == UPD_ALLOC)),
         .i_load_val (c_CTR_ALLOC),
         .o_count    (w_ctr[gi])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < c_ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
         end
      end else begin
         if (bp.flush_all) begin
            r_valid <= '0;
         end else if (w_action == UPD_ALLOC) begin
            r_valid[w_up_idx] <= 1'b1;
            r_tag[w_up_idx]   <= w_up_tag;
         end
         if ((w_action == UPD_INC) || (w_action == UPD_ALLOC)) begin
            r_target[w_up_idx] <= bp.upd_target[ADDR_WIDTH-1:2];
         end
      end
   end

   // The redirect path ignores flush_all: a wrong carried prediction still needs a refetch.
   assign w_mispredict   = bp.upd_valid &&
                           ((bp.upd_taken != bp.upd_pred_taken) ||
                            (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
   assign w_correct_addr = bp.upd_taken ? bp.upd_target : bp.upd_pc + ADDR_WIDTH'(4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_redirect       <= 1'b0;
         r_redirect_addr  <= '0;
         r_mispredict_cnt <= '0;
      end else begin
         r_redirect <= w_mispredict;
         if (w_mispredict) begin
            r_redirect_addr  <= w_correct_addr;
            r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
         end
      end
   end

   assign bp.redirect       = r_redirect;
   assign bp.redirect_addr  = r_redirect_addr;
   assign bp.mispredict_cnt = r_mispredict_cnt;
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// tb_branch_predictor : directed vectors checked against a table-level model
// Revision: 1.0
// ============================================================================
module tb_branch_predictor;
   localparam int AW = 32;
   localparam int IB = 4;
   localparam int CB = 2;
   localparam int N  = 1 << IB;
   localparam int CMAX   = (1 << CB) - 1;
   localparam int THRESH = 1 << (CB - 1);

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   branch_predictor_if #(.ADDR_WIDTH(AW)) bp_bus ();

   branch_predictor #(
      .ADDR_WIDTH (AW),
      .INDEX_BITS (IB),
      .CTR_BITS   (CB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bp    (bp_bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: what each entry holds, in plain integers.
   bit          m_valid [N];
   logic [31:0] m_tag   [N];
   logic [31:0] m_tgt   [N];
   int          m_ctr   [N];
   bit          m_redirect;
   logic [31:0] m_raddr;
   logic [31:0] m_cnt;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic logic [32:0] m_predict(input logic [31:0] pc);
      int i;
      i = idx_of(pc);
      if (m_valid[i] && m_tag[i] == (pc >> (IB + 2)) && m_ctr[i] >= THRESH)
         return {1'b1, m_tgt[i]};
      return {1'b0, pc + 32'd4};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = THRESH - 1;
         end
         m_redirect = 0; m_raddr = 0; m_cnt = 0;
      end else begin
         bit wrong;
         int i;
         bit hit;
         wrong = bp_bus.upd_valid &&
                 (bp_bus.upd_taken != bp_bus.upd_pred_taken ||
                  (bp_bus.upd_taken && bp_bus.upd_target != bp_bus.upd_pred_target));
         m_redirect = wrong;
         if (wrong) begin
            m_raddr = bp_bus.upd_taken ? bp_bus.upd_target : bp_bus.upd_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
         end
         i   = idx_of(bp_bus.upd_pc);
         hit = m_valid[i] && m_tag[i] == (bp_bus.upd_pc >> (IB + 2));
         if (bp_bus.flush_all) begin
            for (int k = 0; k < N; k++) m_valid[k] = 0;
         end else if (bp_bus.upd_valid) begin
            if (hit && bp_bus.upd_taken) begin
               m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
               m_tgt[i] = bp_bus.upd_target & ~32'd3;
            end else if (hit) begin
               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end else if (bp_bus.upd_taken) begin
               m_valid[i] = 1;
               m_tag[i]   = bp_bus.upd_pc >> (IB + 2);
               m_tgt[i]   = bp_bus.upd_target & ~32'd3;
               m_ctr[i]   = THRESH;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         logic [32:0] p;
         p = m_predict(bp_bus.lookup_pc);
         chk("cmp_pred_taken",  {31'd0, bp_bus.pred_taken}, {31'd0, p[32]});
         chk("cmp_pred_target", bp_bus.pred_target, p[31:0]);
         chk("cmp_redirect",    {31'd0, bp_bus.redirect}, {31'd0, m_redirect});
         chk("cmp_redirect_addr", bp_bus.redirect_addr, m_raddr);
         chk("cmp_mispredict_cnt", bp_bus.mispredict_cnt, m_cnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                            input bit ptk, input logic [31:0] ptg, input bit fl);
      bp_bus.upd_valid       = 1'b1;
      bp_bus.upd_pc          = pc;
      bp_bus.upd_taken       = tk;
      bp_bus.upd_target      = tg;
      bp_bus.upd_pred_taken  = ptk;
      bp_bus.upd_pred_target = ptg;
      bp_bus.flush_all       = fl;
   endtask

   task automatic clear_upd();
      bp_bus.upd_valid = 1'b0;
      bp_bus.flush_all = 1'b0;
   endtask

   task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                      input bit ptk, input logic [31:0] ptg);
      drive_upd(pc, tk, tg, ptk, ptg, 1'b0);
      step();
      clear_upd();
   endtask

   task automatic look(input string name, input logic [31:0] pc,
                       input bit exp_tk, input logic [31:0] exp_tg);
      bp_bus.lookup_pc = pc;
      #1;
      chk({name, "_taken"},  {31'd0, bp_bus.pred_taken}, {31'd0, exp_tk});
      chk({name, "_target"}, bp_bus.pred_target, exp_tg);
   endtask

   initial begin
      rst_n = 1'b0;
      bp_bus.lookup_pc = 32'h0040_0010;
      bp_bus.upd_pc = 0; bp_bus.upd_taken = 0; bp_bus.upd_target = 0;
      bp_bus.upd_pred_taken = 0; bp_bus.upd_pred_target = 0;
      clear_upd();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      look("rst_lookup", 32'h0040_0010, 1'b0, 32'h0040_0014);
      chk("rst_redirect", {31'd0, bp_bus.redirect}, 32'd0);
      chk("rst_cnt", bp_bus.mispredict_cnt, 32'd0);

      upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
      chk("first_redirect", {31'd0, bp_bus.redirect}, 32'd1);
      chk("first_raddr", bp_bus.redirect_addr, 32'h0040_0100);
      chk("first_cnt", bp_bus.mispredict_cnt, 32'd1);
      look("first_lookup", 32'h0040_0010, 1'b1, 32'h0040_0100);
      step();
      chk("pulse_end", {31'd0, bp_bus.redirect}, 32'd0);
      chk("raddr_hold", bp_bus.redirect_addr, 32'h0040_0100);

      upd(32'h0040_0050, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0054);
      look("alias_old", 32'h0040_0010, 1'b0, 32'h0040_0014);
      look("alias_new", 32'h0040_0050, 1'b1, 32'h0040_0200);

      upd(32'h0040_0080, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0300);
      upd(32'h0040_0080, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0300);
      upd(32'h0040_0080, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0300);
      look("sat_top", 32'h0040_0080, 1'b1, 32'h0040_0300);
      upd(32'h0040_0080, 1'b0, 32'h0, 1'b1, 32'h0040_0300);
      look("sat_dec1", 32'h0040_0080, 1'b1, 32'h0040_0300);
      upd(32'h0040_0080, 1'b0, 32'h0, 1'b1, 32'h0040_0300);
      look("sat_dec2", 32'h0040_0080, 1'b0, 32'h0040_0084);
      chk("sat_cnt", bp_bus.mispredict_cnt, 32'd4);

      drive_upd(32'h0040_0020, 1'b1, 32'h0040_0400, 1'b0, 32'h0040_0024, 1'b0);
      look("same_old", 32'h0040_0020, 1'b0, 32'h0040_0024);
      step();
      clear_upd();
      look("same_new", 32'h0040_0020, 1'b1, 32'h0040_0400);

      drive_upd(32'h0040_0030, 1'b1, 32'h0040_0500, 1'b0, 32'h0040_0034, 1'b1);
      step();
      clear_upd();
      chk("flush_redirect", {31'd0, bp_bus.redirect}, 32'd1);
      chk("flush_raddr", bp_bus.redirect_addr, 32'h0040_0500);
      look("flush_new", 32'h0040_0030, 1'b0, 32'h0040_0034);
      look("flush_old", 32'h0040_0050, 1'b0, 32'h0040_0054);
      step();

      force dut.r_mispredict_cnt = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      #1 release dut.r_mispredict_cnt;
      upd(32'h0040_0040, 1'b1, 32'h0040_0600, 1'b0, 32'h0040_0044);
      chk("wrap_cnt", bp_bus.mispredict_cnt, 32'd0);
      chk("wrap_redirect", {31'd0, bp_bus.redirect}, 32'd1);
      step();

      drive_upd(32'h0040_0060, 1'b1, 32'h0040_0700, 1'b0, 32'h0040_0064, 1'b0);
      #1 rst_n = 1'b0;
      step();
      clear_upd();
      rst_n = 1'b1;
      chk("midrst_cnt", bp_bus.mispredict_cnt, 32'd0);
      chk("midrst_redirect", {31'd0, bp_bus.redirect}, 32'd0);
      look("midrst_lookup", 32'h0040_0060, 1'b0, 32'h0040_0064);
      look("midrst_prev", 32'h0040_0040, 1'b0, 32'h0040_0044);

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
